// File: rtl/aer_event_decoder.sv
// AER link receiver: 4-phase REQ/ACK handshake, address decode,
// show-ahead pixel-event FIFO and double reset-command detection.
module aer_event_decoder #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_BITS   = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [9:0]          AERIN_ADDR,
    input  logic                AERIN_REQ,
    output logic                AERIN_ACK,
    output logic [7:0]          EVENT_ADDR,
    output logic                EVENT_VALID,
    input  logic                EVENT_READY,
    output logic                NET_RESET,
    output logic [CNT_BITS-1:0] EVENT_COUNT,
    output logic                BUSY
);

    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam logic [9:0]  RST_CMD = 10'h1FF;

    typedef enum logic [1:0] {
        IDLE,
        LATCH,
        ACK
    } state_t;

    typedef logic [AW:0] ptr_t;

    state_t     state;
    logic       req_meta;
    logic       req_s;
    logic [9:0] addr_r;
    logic [1:0] rst_cnt;
    ptr_t       wr_ptr;
    ptr_t       rd_ptr;
    logic [7:0] mem [FIFO_DEPTH];

    logic fifo_empty;
    logic fifo_full;
    logic is_pixel;
    logic is_cmd;
    logic decode;
    logic push;
    logic pop;
    logic flush;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign is_pixel   = (addr_r[9:8] == 2'b00);
    assign is_cmd     = (addr_r == RST_CMD);
    assign decode     = (state == LATCH);
    assign push       = decode && is_pixel;
    assign flush      = decode && is_cmd && (rst_cnt == 2'd1);
    assign pop        = !fifo_empty && EVENT_READY;

    assign EVENT_VALID = !fifo_empty;
    assign EVENT_ADDR  = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign BUSY        = (state != IDLE) || !fifo_empty;

    // Two-flop synchroniser for the asynchronous request line
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            req_meta <= 1'b0;
            req_s    <= 1'b0;
        end else begin
            req_meta <= AERIN_REQ;
            req_s    <= req_meta;
        end
    end

    // Handshake FSM with registered ACK, decode and event bookkeeping
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            addr_r      <= '0;
            rst_cnt     <= '0;
            AERIN_ACK   <= 1'b0;
            NET_RESET   <= 1'b0;
            EVENT_COUNT <= '0;
        end else begin
            NET_RESET <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_s && !fifo_full) begin
                        addr_r <= AERIN_ADDR;
                        state  <= LATCH;
                    end
                end
                LATCH: begin
                    AERIN_ACK <= 1'b1;
                    state     <= ACK;
                    if (is_pixel) begin
                        rst_cnt <= '0;
                        if (EVENT_COUNT != '1)
                            EVENT_COUNT <= EVENT_COUNT + CNT_BITS'(1);
                    end else if (is_cmd) begin
                        if (rst_cnt == 2'd1) begin
                            NET_RESET   <= 1'b1;
                            EVENT_COUNT <= '0;
                        end
                        if (rst_cnt != 2'd2)
                            rst_cnt <= rst_cnt + 2'd1;
                    end
                end
                ACK: begin
                    if (!req_s) begin
                        AERIN_ACK <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO pointers; a flush overrides a coincident pop
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + ptr_t'(1);
            if (pop)
                rd_ptr <= rd_ptr + ptr_t'(1);
        end
    end

    // FIFO storage, written only on a decoded pixel event
    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= addr_r[7:0];
    end

endmodule

// File: doc/aer_event_decoder.md
# aer_event_decoder

Receiving end of the 10-bit AER link driven by the image encoder. The block completes a 4-phase REQ/ACK handshake per event and decodes each address. Pixel events go into a show-ahead FIFO for the neuron core. Two consecutive reset-command events (10'h1FF) raise a one-cycle network-reset pulse.

## Interface
Parameters:
- FIFO_DEPTH, 8: pixel-event FIFO entries; power of two, ≥2.
- CNT_BITS, 16: width of the accepted-event counter.

Ports (clock and reset first):
- CLK  in  1  single clock for the block.
- RST_N  in  1  asynchronous, active-low reset.
- AERIN_ADDR  in  10  AER address; stable while AERIN_REQ is high.
- AERIN_REQ  in  1  AER request; asynchronous to CLK.
- AERIN_ACK  out  1  AER acknowledge; registered.
- EVENT_ADDR  out  8  pixel event at the FIFO head.
- EVENT_VALID  out  1  FIFO not empty.
- EVENT_READY  in  1  consumer pops the FIFO head when high together with EVENT_VALID.
- NET_RESET  out  1  one-cycle network-reset pulse.
- EVENT_COUNT  out  CNT_BITS  pixel events accepted since the last reset.
- BUSY  out  1  high when the state is not IDLE or the FIFO is non-empty.

## Operation
- AERIN_REQ passes through a 2-flop synchroniser to give req_s. Only req_s drives control logic.
- FSM states: IDLE, LATCH, ACK.
  - IDLE → LATCH when req_s=1 and the FIFO is not full. AERIN_ADDR is captured into addr_r on this edge.
  - IDLE holds while the FIFO is full. ACK is withheld, which backpressures the sender; this applies to every event type.
  - LATCH → ACK unconditionally. The decode actions below happen on this edge, and AERIN_ACK goes to 1.
  - ACK → IDLE when req_s=0. AERIN_ACK goes to 0 on this edge.
- Decode of addr_r:
  - addr_r[9:8]=2'b00 is a pixel event. Push addr_r[7:0] into the FIFO, increment EVENT_COUNT (saturating at all-ones), and clear rst_cnt.
  - addr_r=10'h1FF is a reset command. rst_cnt is 2 bits and saturates at 2.
    - On the 1→2 transition: pulse NET_RESET, flush the FIFO, and clear EVENT_COUNT.
    - A command that arrives while rst_cnt=2 has no further effect.
  - Any other address is acknowledged and discarded. No push; EVENT_COUNT and rst_cnt are unchanged.
- FIFO behaviour:
  - Show-ahead: EVENT_ADDR is valid whenever EVENT_VALID=1.
  - Pop on EVENT_VALID && EVENT_READY.
  - Simultaneous push and pop leaves occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer bit.
  - When a flush and a pop occur on the same edge, the flush wins and the FIFO ends empty.
  - A push and a flush can never coincide, because each decoded event is either a push or a command.
- Reset values: AERIN_ACK=0, EVENT_VALID=0, EVENT_ADDR=0, NET_RESET=0, EVENT_COUNT=0, BUSY=0. The FSM is in IDLE, the synchroniser holds 0, and rst_cnt=0.
- Reset asserted mid-handshake:
  - The handshake is abandoned and ACK drops asynchronously.
  - If REQ is still high after reset is released, the event is re-captured as a new event.

## Timing
- Let REQ first be sampled high at edge E0. Then:
  - req_s=1 after E1.
  - LATCH after E2.
  - AERIN_ACK=1 after E3, so the REQ→ACK latency is 3 cycles.
  - The push, the EVENT_COUNT update and NET_RESET all become visible after E3.
  - EVENT_VALID rises after E3 if the FIFO was empty.
- Let REQ first be sampled low at edge F0. AERIN_ACK=0 after F2, and the block is ready for the next REQ.
- Minimum handshake turnaround is 6 cycles, given zero sender delay.
- NET_RESET is high for exactly one cycle per 1→2 transition of rst_cnt.
- If the FIFO is full while REQ is high, ACK is delayed until the first pop. LATCH is entered on the edge after the cycle in which the pop frees an entry.

## Test plan
- Single pixel event: ADDR=10'h02A, full handshake → EVENT_ADDR=8'h2A and EVENT_VALID=1 after E3; ACK rises 3 cycles after REQ is sampled; EVENT_COUNT=1.
- Reset sequence: 1FF, 1FF, 1FF, then pixel 10'h005 → exactly one NET_RESET pulse, issued on the second command; EVENT_COUNT=0 before the pixel and 1 after it; the FIFO holds only 8'h05.
- Interrupted reset: 1FF, pixel 10'h010, 1FF → no NET_RESET pulse; EVENT_COUNT=1.
- Backpressure:
  - Stimulus: EVENT_READY=0, FIFO_DEPTH+1 pixel events 0..8.
  - Response: the 9th REQ is not acknowledged and BUSY=1.
  - Then pulse READY for one cycle → the 9th is acknowledged, and the FIFO drains 0..8 in order.
- Flush with pop: FIFO holds 3 entries and READY=1 on the edge where the second 1FF decodes → FIFO ends empty and EVENT_VALID=0.
- Illegal address 10'h2FF, then RST_N pulsed low while ACK=1 with REQ held high → first event: acknowledged, no push, count unchanged. During RST_N low: ACK=0 and all outputs at reset values. After release: the event is re-captured and the handshake completes.
